// File: rtl/dual_ram_port_arb_if.sv
// Requester and RAM-port signals of dual_ram_port_arb; slave = arbiter side, master = client/RAM side.
// Requests are held until granted; read returns carry no backpressure.
interface dual_ram_port_arb_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          i_req_a;
  logic          i_we_a;
  logic [AW-1:0] i_addr_a;
  logic [DW-1:0] i_wdata_a;
  logic          o_gnt_a;
  logic          o_rvalid_a;
  logic [DW-1:0] o_rdata_a;

  logic          i_req_b;
  logic          i_we_b;
  logic [AW-1:0] i_addr_b;
  logic [DW-1:0] i_wdata_b;
  logic          o_gnt_b;
  logic          o_rvalid_b;
  logic [DW-1:0] o_rdata_b;

  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_data;
  logic          o_ram_wr_en;
  logic [DW-1:0] i_ram_data;
  logic          o_busy;

  modport slave (
    input  i_req_a, i_we_a, i_addr_a, i_wdata_a,
    input  i_req_b, i_we_b, i_addr_b, i_wdata_b,
    input  i_ram_data,
    output o_gnt_a, o_rvalid_a, o_rdata_a,
    output o_gnt_b, o_rvalid_b, o_rdata_b,
    output o_ram_addr, o_ram_data, o_ram_wr_en, o_busy
  );

  modport master (
    output i_req_a, i_we_a, i_addr_a, i_wdata_a,
    output i_req_b, i_we_b, i_addr_b, i_wdata_b,
    output i_ram_data,
    input  o_gnt_a, o_rvalid_a, o_rdata_a,
    input  o_gnt_b, o_rvalid_b, o_rdata_b,
    input  o_ram_addr, o_ram_data, o_ram_wr_en, o_busy
  );
endinterface

// File: rtl/dual_ram_port_arb.sv
// Round-robin share of one dual_ram port between A and B; combinational grant, RAM port one cycle later, rvalid RD_LAT+1 after grant.
// Losing requester holds req (no queueing); read returns are unconditional strobes with no backpressure.
module dual_ram_port_arb #(
  parameter int AW     = 5,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  dual_ram_port_arb_if.slave io_bus
);
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;

  req_id_e       r_last_gnt;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_data;
  logic          r_ram_wr_en;
  logic [RD_LAT:0] r_pv;
  logic [RD_LAT:0] r_pid;
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;

  logic w_gnt_a;
  logic w_gnt_b;
  logic w_rd;

  assign w_gnt_a = !rst && io_bus.i_req_a && (!io_bus.i_req_b || r_last_gnt == REQ_B);
  assign w_gnt_b = !rst && io_bus.i_req_b && (!io_bus.i_req_a || r_last_gnt == REQ_A);
  assign w_rd    = (w_gnt_a && !io_bus.i_we_a) || (w_gnt_b && !io_bus.i_we_b);

  // The last pipeline stage doubles as the rvalid register: RAM data is valid while
  // stage RD_LAT-1 is occupied and is captured on the edge that advances it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt  <= REQ_B;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ram_wr_en <= 1'b0;
      r_pv        <= '0;
      r_pid       <= '0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
    end else begin
      r_ram_wr_en <= 1'b0;
      if (w_gnt_a) begin
        r_last_gnt  <= REQ_A;
        r_ram_addr  <= io_bus.i_addr_a;
        r_ram_data  <= io_bus.i_wdata_a;
        r_ram_wr_en <= io_bus.i_we_a;
      end else if (w_gnt_b) begin
        r_last_gnt  <= REQ_B;
        r_ram_addr  <= io_bus.i_addr_b;
        r_ram_data  <= io_bus.i_wdata_b;
        r_ram_wr_en <= io_bus.i_we_b;
      end
      r_pv  <= {r_pv[RD_LAT-1:0], w_rd};
      r_pid <= {r_pid[RD_LAT-1:0], w_gnt_b};
      if (r_pv[RD_LAT-1]) begin
        if (r_pid[RD_LAT-1]) r_rdata_b <= io_bus.i_ram_data;
        else                 r_rdata_a <= io_bus.i_ram_data;
      end
    end
  end

  assign io_bus.o_gnt_a     = w_gnt_a;
  assign io_bus.o_gnt_b     = w_gnt_b;
  assign io_bus.o_ram_addr  = r_ram_addr;
  assign io_bus.o_ram_data  = r_ram_data;
  assign io_bus.o_ram_wr_en = r_ram_wr_en;
  assign io_bus.o_rvalid_a  = r_pv[RD_LAT] && !r_pid[RD_LAT];
  assign io_bus.o_rvalid_b  = r_pv[RD_LAT] && r_pid[RD_LAT];
  assign io_bus.o_rdata_a   = r_rdata_a;
  assign io_bus.o_rdata_b   = r_rdata_b;
  assign io_bus.o_busy      = |r_pv;
endmodule
